mux_arbiter4: RTL and testbench

MUX_ARBITER4 -- requirements
Module: mux_arbiter4

---
 rtl/mux_arbiter4.sv | 125 ++++++++++++
 tb/tb_mux_arbiter4.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter4.sv
// rtl/mux_arbiter4.sv - four-way round-robin arbiter with bounded hold and a one-bit data mux
module mux_arbiter4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       data_out
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;

    logic [3:0] others;
    logic [2:0] pick_all, pick_oth;
    logic       take;
    logic [1:0] winner;

    // Returns {found, index}; scans start+1 .. start+4 so the nearest requester after start wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        take     = 1'b0;
        winner   = 2'd0;
        others   = req & ~(4'b0001 << sel_q);
        pick_all = rr_pick(req, ptr_q);
        pick_oth = rr_pick(others, ptr_q);

        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    take   = 1'b1;
                    winner = pick_all[1:0];
                end else begin
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    if (hold_q < HOLD_LAST) begin
                        hold_d = hold_q + 4'd1;
                    end else if (pick_oth[2]) begin
                        take   = 1'b1;
                        winner = pick_oth[1:0];
                    end else begin
                        hold_d = HOLD_LAST;
                    end
                end else if (pick_all[2]) begin
                    take   = 1'b1;
                    winner = pick_all[1:0];
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << winner;
            sel_d   = winner;
            valid_d = 1'b1;
            ptr_d   = winner;
            hold_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b11;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign valid    = valid_q;
    assign data_out = valid_q ? data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_arbiter4.sv
// tb/tb_mux_arbiter4.sv - scoreboard bench for mux_arbiter4 against a behavioural arbitration model
module tb_mux_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       data_out;

    mux_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    // Model: owner = granted index or -1, last = most recent winner, held = cycles owner has had it.
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    int m_sel   = 0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq);
        int   cand;
        int   idx;
        bit   owner_req;
        exp_t x;
        owner_req = (m_owner >= 0) && rq[m_owner];
        if (r) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
            m_sel   = 0;
        end else if (owner_req && (m_held < MAX_HOLD || rq == 4'(1 << m_owner))) begin
            m_held++;
        end else begin
            cand = -1;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (cand < 0 && rq[idx] && !(owner_req && idx == m_owner)) cand = idx;
            end
            if (cand < 0) begin
                m_owner = -1;
            end else begin
                m_owner = cand;
                m_last  = cand;
                m_held  = 1;
                m_sel   = cand;
            end
        end
        x.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        x.sel   = 2'(m_sel);
        x.valid = (m_owner >= 0);
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] d);
        @(negedge clk);
        rst     = r;
        req     = rq;
        data_in = d;
        model_step(r, rq);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", int'(gnt), int'(e.gnt));
                check("sel", int'(sel), int'(e.sel));
                check("valid", int'(valid), int'(e.valid));
                check("data_out", int'(data_out), e.valid ? int'(data_in[e.sel]) : 0);
                check("gnt_onehot", int'($countones(gnt) <= 1), 1);
                check("valid_vs_gnt", int'(valid), int'(|gnt));
            end
        end
    end

    initial begin
        logic [3:0] r_req;
        rst     = 1'b1;
        req     = 4'b0000;
        data_in = 4'b0000;

        repeat (2) drive(1'b1, 4'b0000, 4'b0000);
        repeat (3) drive(1'b0, 4'b0001, 4'b0001);

        drive(1'b1, 4'b0000, 4'b0000);
        repeat (22) drive(1'b0, 4'b1111, 4'($urandom));

        drive(1'b1, 4'b0000, 4'b0000);
        repeat (20) drive(1'b0, 4'b0100, 4'($urandom));
        repeat (3) drive(1'b0, 4'b0000, 4'($urandom));

        drive(1'b1, 4'b0000, 4'b0000);
        repeat (2) drive(1'b0, 4'b0010, 4'($urandom));
        repeat (3) drive(1'b0, 4'b1001, 4'($urandom));

        // Ten cycles of 1111 from reset leaves requester 2 mid-grant when reset hits.
        drive(1'b1, 4'b0000, 4'b0000);
        repeat (10) drive(1'b0, 4'b1111, 4'($urandom));
        drive(1'b1, 4'b1111, 4'($urandom));
        repeat (3) drive(1'b0, 4'b1111, 4'($urandom));

        r_req = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
            drive(($urandom_range(0, 199) == 0), r_req, 4'($urandom));
        end
        repeat (3) drive(1'b0, 4'b0000, 4'($urandom));

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
